itu_timer_array: RTL and testbench

Parametrised multi-channel 16/32-bit timer unit. It generalises the on-chip integrated timer pulse unit to CHANNELS identical channels of WIDTH bits. Each channel adds down-counting, PWM mode, buffered compare/capture (GRx↔BRx) and an underflow flag. It sits on the peripheral register bus next to the interrupt controller and drives per-channel compare outputs and IRQ lines.

---
 rtl/itu_timer_array.sv | 237 +++++++++++++++++++++++
 tb/tb_itu_timer_array.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/itu_timer_array.sv
// itu_timer_array: CHANNELS identical WIDTH-bit timer channels with
// compare, capture, PWM and buffered GR/BR registers on a word bus.
module itu_timer_array #(
  parameter int CHANNELS = 5,
  parameter int WIDTH    = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CE,
  input  logic [CHANNELS-1:0] TCLK,
  input  logic [CHANNELS-1:0] TIOCAI,
  input  logic [CHANNELS-1:0] TIOCBI,
  output logic [CHANNELS-1:0] TIOCAO,
  output logic [CHANNELS-1:0] TIOCBO,
  input  logic [7:0]          REG_ADDR,
  input  logic [31:0]         REG_DI,
  input  logic                REG_WE,
  input  logic                REG_RE,
  output logic [31:0]         REG_DO,
  output logic [CHANNELS-1:0] IMIA_IRQ,
  output logic [CHANNELS-1:0] IMIB_IRQ,
  output logic [CHANNELS-1:0] OVI_IRQ
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = 1;

  logic [2:0]          div_q, div_d;
  logic [CHANNELS-1:0] start_q, start_d;
  logic [31:0]         do_q, do_d, rd_data;
  logic [3:0]          sel_ch;
  logic [2:0]          sel_reg;
  logic                sel_ok;
  logic [WIDTH-1:0]    wdat;
  logic                unused_di;

  // Read views padded to 16 so a 4-bit channel index is always in range.
  logic [15:0]      ctrl_v [16];
  logic [3:0]       stat_v [16];
  logic [WIDTH-1:0] cnt_v  [16];
  logic [WIDTH-1:0] gra_v  [16];
  logic [WIDTH-1:0] grb_v  [16];
  logic [WIDTH-1:0] bra_v  [16];
  logic [WIDTH-1:0] brb_v  [16];

  assign sel_ch    = REG_ADDR[6:3];
  assign sel_reg   = REG_ADDR[2:0];
  assign sel_ok    = !REG_ADDR[7];
  assign wdat      = REG_DI[WIDTH-1:0];
  assign unused_di = ^REG_DI;
  assign REG_DO    = do_q;

  for (genvar c = 0; c < 16; c++) begin : g_ch
    if (c < CHANNELS) begin : g_on
      logic [15:0]      ctrl_q, ctrl_d;
      logic [3:0]       stat_q, stat_d;
      logic [WIDTH-1:0] cnt_q, cnt_d, gra_q, gra_d, grb_q, grb_d;
      logic [WIDTH-1:0] bra_q, bra_d, brb_q, brb_d;
      logic             ao_q, ao_d, bo_q, bo_d;
      logic             tclk_q, tclk_d, ai_q, ai_d, bi_q, bi_d;
      logic             wr, tick, run, pwm, up, bufa, bufb;
      logic             mat_a, mat_b, clr_a, clr_b, cap_a, cap_b;
      logic             ovf, udf, edge_a, edge_b;
      logic [1:0]       cclr, ioa, iob;

      assign pwm  = ctrl_q[6];
      assign up   = pwm || !ctrl_q[5];
      assign bufa = ctrl_q[7];
      assign bufb = ctrl_q[8];
      assign cclr = ctrl_q[4:3];
      assign ioa  = ctrl_q[10:9];
      assign iob  = ctrl_q[12:11];
      assign wr   = REG_WE && sel_ok && (sel_ch == 4'(c));

      always_comb begin
        unique case (ctrl_q[2:0])
          3'd0:    tick = CE;
          3'd1:    tick = CE && div_q[0];
          3'd2:    tick = CE && (div_q[1:0] == 2'b11);
          3'd3:    tick = CE && (div_q == 3'b111);
          3'd4:    tick = CE && TCLK[c] && !tclk_q;
          3'd5:    tick = CE && !TCLK[c] && tclk_q;
          3'd6:    tick = CE && (TCLK[c] != tclk_q);
          default: tick = 1'b0;
        endcase
      end

      assign run    = tick && start_q[c];
      assign mat_a  = run && (pwm || !ioa[1]) && (cnt_q == gra_q);
      assign mat_b  = run && (pwm || !iob[1]) && (cnt_q == grb_q);
      assign clr_a  = mat_a && (pwm || cclr == 2'b01);
      assign clr_b  = mat_b && !pwm && cclr == 2'b10;
      assign edge_a = ioa[0] ? (!TIOCAI[c] && ai_q) : (TIOCAI[c] && !ai_q);
      assign edge_b = iob[0] ? (!TIOCBI[c] && bi_q) : (TIOCBI[c] && !bi_q);
      assign cap_a  = CE && !pwm && ioa[1] && edge_a;
      assign cap_b  = CE && !pwm && iob[1] && edge_b;
      assign ovf    = run && up && !clr_a && !clr_b && cnt_q == MAX;
      assign udf    = run && !up && !clr_a && !clr_b && cnt_q == '0;

      always_comb begin
        ctrl_d = ctrl_q;
        stat_d = stat_q;
        cnt_d  = cnt_q;
        gra_d  = gra_q;
        grb_d  = grb_q;
        bra_d  = bra_q;
        brb_d  = brb_q;
        ao_d   = ao_q;
        bo_d   = bo_q;
        tclk_d = CE ? TCLK[c] : tclk_q;
        ai_d   = CE ? TIOCAI[c] : ai_q;
        bi_d   = CE ? TIOCBI[c] : bi_q;
        if (run) begin
          if (clr_a)      cnt_d = up ? '0 : gra_q;
          else if (clr_b) cnt_d = up ? '0 : grb_q;
          else if (up)    cnt_d = cnt_q + ONE;
          else            cnt_d = cnt_q - ONE;
        end
        if ((cap_a && cclr == 2'b01) || (cap_b && cclr == 2'b10))
          cnt_d = '0;
        if (pwm) begin
          if (mat_b) ao_d = 1'b0;
          if (mat_a) ao_d = 1'b1;
        end else begin
          if (mat_a && ioa == 2'b01) ao_d = !ao_q;
          if (mat_b && iob == 2'b01) bo_d = !bo_q;
        end
        if (mat_a && bufa) gra_d = bra_q;
        if (mat_b && bufb) grb_d = brb_q;
        if (cap_a && bufa) bra_d = gra_q;
        if (cap_b && bufb) brb_d = grb_q;
        if (wr) begin
          unique case (sel_reg)
            3'd0:    ctrl_d = REG_DI[15:0];
            3'd1:    stat_d = stat_q & ~REG_DI[3:0];
            3'd2:    cnt_d  = wdat;
            3'd3:    gra_d  = wdat;
            3'd4:    grb_d  = wdat;
            3'd5:    bra_d  = wdat;
            3'd6:    brb_d  = wdat;
            default: ;
          endcase
        end
        if (cap_a) gra_d = cnt_q;
        if (cap_b) grb_d = cnt_q;
        stat_d = stat_d | {udf, ovf, mat_b || cap_b, mat_a || cap_a};
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          ctrl_q <= '0;
          stat_q <= '0;
          cnt_q  <= '0;
          gra_q  <= '0;
          grb_q  <= '0;
          bra_q  <= '0;
          brb_q  <= '0;
          ao_q   <= 1'b0;
          bo_q   <= 1'b0;
          tclk_q <= 1'b0;
          ai_q   <= 1'b0;
          bi_q   <= 1'b0;
        end else begin
          ctrl_q <= ctrl_d;
          stat_q <= stat_d;
          cnt_q  <= cnt_d;
          gra_q  <= gra_d;
          grb_q  <= grb_d;
          bra_q  <= bra_d;
          brb_q  <= brb_d;
          ao_q   <= ao_d;
          bo_q   <= bo_d;
          tclk_q <= tclk_d;
          ai_q   <= ai_d;
          bi_q   <= bi_d;
        end
      end

      assign TIOCAO[c]   = ao_q;
      assign TIOCBO[c]   = bo_q;
      assign IMIA_IRQ[c] = stat_q[0] & ctrl_q[13];
      assign IMIB_IRQ[c] = stat_q[1] & ctrl_q[14];
      assign OVI_IRQ[c]  = (stat_q[2] | stat_q[3]) & ctrl_q[15];
      assign ctrl_v[c]   = ctrl_q;
      assign stat_v[c]   = stat_q;
      assign cnt_v[c]    = cnt_q;
      assign gra_v[c]    = gra_q;
      assign grb_v[c]    = grb_q;
      assign bra_v[c]    = bra_q;
      assign brb_v[c]    = brb_q;
    end else begin : g_off
      assign ctrl_v[c] = '0;
      assign stat_v[c] = '0;
      assign cnt_v[c]  = '0;
      assign gra_v[c]  = '0;
      assign grb_v[c]  = '0;
      assign bra_v[c]  = '0;
      assign brb_v[c]  = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel_ok) begin
      unique case (sel_reg)
        3'd0:    rd_data[15:0]      = ctrl_v[sel_ch];
        3'd1:    rd_data[3:0]       = stat_v[sel_ch];
        3'd2:    rd_data[WIDTH-1:0] = cnt_v[sel_ch];
        3'd3:    rd_data[WIDTH-1:0] = gra_v[sel_ch];
        3'd4:    rd_data[WIDTH-1:0] = grb_v[sel_ch];
        3'd5:    rd_data[WIDTH-1:0] = bra_v[sel_ch];
        3'd6:    rd_data[WIDTH-1:0] = brb_v[sel_ch];
        default: rd_data = '0;
      endcase
    end else if (REG_ADDR == 8'h80) begin
      rd_data[CHANNELS-1:0] = start_q;
    end
  end

  always_comb begin
    div_d   = CE ? div_q + 3'd1 : div_q;
    start_d = start_q;
    if (REG_WE && REG_ADDR == 8'h80) start_d = REG_DI[CHANNELS-1:0];
    do_d    = REG_RE ? rd_data : do_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q   <= '0;
      start_q <= '0;
      do_q    <= '0;
    end else begin
      div_q   <= div_d;
      start_q <= start_d;
      do_q    <= do_d;
    end
  end
endmodule

// File: tb/tb_itu_timer_array.sv
// Directed bench for itu_timer_array: compare/clear, down count,
// capture, prescaler, external clock, PWM with buffering, reset.
module tb_itu_timer_array;
  localparam int CH = 5;

  logic          CLK, RST, CE;
  logic [CH-1:0] TCLK, TIOCAI, TIOCBI;
  logic [CH-1:0] TIOCAO, TIOCBO, IMIA_IRQ, IMIB_IRQ, OVI_IRQ;
  logic [7:0]    REG_ADDR;
  logic [31:0]   REG_DI, REG_DO;
  logic          REG_WE, REG_RE;

  int vectors = 0;
  int miscompares = 0;

  itu_timer_array #(.CHANNELS(CH), .WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .TCLK(TCLK),
    .TIOCAI(TIOCAI), .TIOCBI(TIOCBI),
    .TIOCAO(TIOCAO), .TIOCBO(TIOCBO),
    .REG_ADDR(REG_ADDR), .REG_DI(REG_DI),
    .REG_WE(REG_WE), .REG_RE(REG_RE), .REG_DO(REG_DO),
    .IMIA_IRQ(IMIA_IRQ), .IMIB_IRQ(IMIB_IRQ), .OVI_IRQ(OVI_IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    REG_ADDR = a;
    REG_DI = d;
    REG_WE = 1'b1;
    @(posedge CLK); #1;
    REG_WE = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    REG_ADDR = a;
    REG_RE = 1'b1;
    @(posedge CLK); #1;
    REG_RE = 1'b0;
    d = REG_DO;
  endtask

  // REG_DO streams CNT; measures cycles between successive changes.
  task automatic measure(input int n, input bit tog, input int want,
                         input string tag);
    int last, ni;
    int iv [3];
    logic [15:0] prev, v;
    last = -1;
    ni = 0;
    iv = '{0, 0, 0};
    prev = REG_DO[15:0];
    for (int i = 0; i < n; i++) begin
      if (tog) CE = ~CE;
      @(posedge CLK); #1;
      v = REG_DO[15:0];
      if (v != prev) begin
        if (last >= 0 && ni < 3) begin
          iv[ni] = i - last;
          ni++;
        end
        last = i;
      end
      prev = v;
    end
    CE = 1'b1;
    check({tag, "_n"}, 32'(ni), 32'd3);
    for (int j = 0; j < 3; j++) check(tag, 32'(iv[j]), 32'(want));
  endtask

  initial begin
    logic [31:0] d, c0, c1;
    logic [31:0] dn [5];
    int rises [8];
    int falls [8];
    int nr, nf;
    logic prev_ao, ao;

    RST = 1'b1; CE = 1'b1;
    TCLK = '0; TIOCAI = '0; TIOCBI = '0;
    REG_ADDR = '0; REG_DI = '0; REG_WE = 1'b0; REG_RE = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset state and address decode
    check("rst_ao", 32'(TIOCAO), 32'd0);
    check("rst_bo", 32'(TIOCBO), 32'd0);
    check("rst_irq", 32'({IMIA_IRQ, IMIB_IRQ, OVI_IRQ}), 32'd0);
    check("rst_do", REG_DO, 32'd0);
    rd(8'h00, d); check("rst_ctrl0", d, 32'd0);
    rd(8'h80, d); check("rst_start", d, 32'd0);
    wr(8'h07, 32'hFF); rd(8'h07, d); check("resv", d, 32'd0);
    wr(8'h40, 32'h1234); rd(8'h40, d); check("unmapped", d, 32'd0);

    // Up count /1, clear on GRA=4, toggle A
    wr(8'h03, 32'd4);
    wr(8'h00, 32'h0208);
    wr(8'h80, 32'h01);
    REG_ADDR = 8'h02; REG_RE = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge CLK); #1;
      check("up_cnt", REG_DO, 32'((k - 1) % 5));
      check("up_ao", 32'(TIOCAO[0]), 32'((k / 5) % 2));
    end
    REG_RE = 1'b0;
    wr(8'h80, 32'h00);
    rd(8'h01, d); check("up_stat", d, 32'h3);
    check("up_irq_off", 32'(IMIA_IRQ[0]), 32'd0);
    wr(8'h00, 32'h2208);
    check("up_irq_on", 32'(IMIA_IRQ[0]), 32'd1);

    // Down count on channel 1 through zero
    dn = '{32'd2, 32'd1, 32'd0, 32'hFFFF, 32'hFFFE};
    wr(8'h0A, 32'd2);
    wr(8'h08, 32'h8020);
    wr(8'h80, 32'h02);
    REG_ADDR = 8'h0A; REG_RE = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge CLK); #1;
      check("dn_cnt", REG_DO, dn[k-1]);
    end
    REG_RE = 1'b0;
    check("dn_ovi", 32'(OVI_IRQ[1]), 32'd1);
    wr(8'h80, 32'h00);
    rd(8'h09, d); check("dn_stat", d, 32'hB);
    wr(8'h09, 32'h0); rd(8'h09, d); check("dn_w0", d, 32'hB);
    wr(8'h09, 32'h8); rd(8'h09, d); check("dn_w8", d, 32'h3);
    check("dn_ovi_clr", 32'(OVI_IRQ[1]), 32'd0);

    // Capture A rising on channel 3, buffered, CPU write loses
    wr(8'h18, 32'h0480);
    wr(8'h80, 32'h08);
    for (int k = 1; k <= 14; k++) begin
      @(posedge CLK); #1;
      if (k == 5) TIOCAI[3] = 1'b1;
      if (k == 6) TIOCAI[3] = 1'b0;
      if (k == 12) begin
        TIOCAI[3] = 1'b1;
        REG_ADDR = 8'h1B; REG_DI = 32'h77; REG_WE = 1'b1;
      end
      if (k == 13) REG_WE = 1'b0;
    end
    wr(8'h80, 32'h00);
    rd(8'h1B, d); check("cap_gra", d, 32'd12);
    rd(8'h1D, d); check("cap_bra", d, 32'd5);
    rd(8'h19, d); check("cap_imfa", d & 32'h1, 32'h1);

    // Prescaler /8 on channel 4, then CE at half rate
    wr(8'h20, 32'h3);
    wr(8'h80, 32'h10);
    REG_ADDR = 8'h22; REG_RE = 1'b1;
    @(posedge CLK); #1;
    measure(48, 1'b0, 8, "psc8");
    measure(80, 1'b1, 16, "psc8_ce");
    REG_RE = 1'b0;

    // External clock, both edges
    wr(8'h20, 32'h6);
    rd(8'h22, c0);
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) TCLK[4] = ~TCLK[4];
      @(posedge CLK); #1;
    end
    rd(8'h22, c1);
    check("tclk_both", (c1 - c0) & 32'hFFFF, 32'd6);

    // PWM on channel 2, GRA=9 GRB=3, then buffered period 20
    wr(8'h13, 32'd9);
    wr(8'h14, 32'd3);
    wr(8'h15, 32'd9);
    wr(8'h10, 32'h20C0);
    rd(8'h14, d); check("pwm_grb", d, 32'd3);
    wr(8'h80, 32'h04);
    nr = 0; nf = 0; prev_ao = 1'b0;
    for (int k = 1; k <= 53; k++) begin
      @(posedge CLK); #1;
      ao = TIOCAO[2];
      if (ao && !prev_ao && nr < 8) begin rises[nr] = k; nr++; end
      if (!ao && prev_ao && nf < 8) begin falls[nf] = k; nf++; end
      prev_ao = ao;
      if (k == 22) begin
        REG_ADDR = 8'h15; REG_DI = 32'd19; REG_WE = 1'b1;
      end
      if (k == 23) REG_WE = 1'b0;
    end
    check("pwm_nr", 32'(nr), 32'd4);
    check("pwm_nf", 32'(nf), 32'd3);
    check("pwm_r0", 32'(rises[0]), 32'd10);
    check("pwm_r1", 32'(rises[1]), 32'd20);
    check("pwm_r2", 32'(rises[2]), 32'd30);
    check("pwm_r3", 32'(rises[3]), 32'd50);
    check("pwm_f0", 32'(falls[0]), 32'd14);
    check("pwm_f1", 32'(falls[1]), 32'd24);
    check("pwm_f2", 32'(falls[2]), 32'd34);
    check("pwm_ao_hi", 32'(TIOCAO[2]), 32'd1);
    check("pwm_irq_hi", 32'(IMIA_IRQ[2]), 32'd1);
    check("pwm_do_hold", REG_DO, 32'd3);

    // Asynchronous reset mid-PWM
    #2 RST = 1'b1;
    #1;
    check("arst_ao", 32'(TIOCAO), 32'd0);
    check("arst_irq", 32'({IMIA_IRQ, IMIB_IRQ, OVI_IRQ}), 32'd0);
    check("arst_do", REG_DO, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    rd(8'h10, d); check("arst_ctrl", d, 32'd0);
    rd(8'h80, d); check("arst_start", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
